// File: rtl/sensor_pkg.sv
// Shared types and default sizing for the line-scan sensor controller.
package sensor_pkg;

  localparam int unsigned NUM_PIXELS_DEF = 128;
  localparam int unsigned ADC_W_DEF      = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_SI    = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DRAIN = 3'd4
  } scan_state_t;

endpackage

// File: rtl/pix_out_buf.sv
// One-entry valid/ready output register for pixel samples.
// A sample arriving while the entry is full and not being popped is dropped
// and flags a sticky overrun, cleared only by clr_overrun.
module pix_out_buf #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned IDX_W    = 7,
  parameter int unsigned LAST_IDX = 127
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic              clr_overrun,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic              overrun
);

  logic pop_c;

  assign pop_c = valid & ready;

  // Entry state: load when empty or draining this cycle, otherwise drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      data    <= '0;
      idx     <= '0;
      last    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clr_overrun) begin
        overrun <= 1'b0;
      end
      if (load) begin
        if (!valid || pop_c) begin
          valid <= 1'b1;
          data  <= load_data;
          idx   <= load_idx;
          last  <= (load_idx == IDX_W'(LAST_IDX));
        end else begin
          overrun <= 1'b1;
        end
      end else if (pop_c) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_controller.sv
// Line-scan image sensor readout controller.
// Generates the SI frame-start pulse, one ADC convert strobe per pixel on each
// falling sensor clock edge, and streams samples out over valid/ready.
// Build option: define SCAN_CONTINUOUS_EN for free-running frames after the
// first start (DRAIN returns to ARM, busy stays high).
module sensor_scan_controller
  import sensor_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned ADC_W      = ADC_W_DEF
) (
  input  logic                          clk_3M,
  input  logic                          reset,
  input  logic                          sensor_clk,
  input  logic                          start,
  output logic                          si,
  output logic                          adc_conv,
  input  logic                          adc_valid,
  input  logic [ADC_W-1:0]              adc_data,
  output logic [ADC_W-1:0]              pix_data,
  output logic [$clog2(NUM_PIXELS)-1:0] pix_idx,
  output logic                          pix_last,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int unsigned IDX_W = $clog2(NUM_PIXELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  logic [1:0]       rst_sync;
  logic             rst_n;
  scan_state_t      state;
  logic             sclk_q;
  logic             si_rise_seen;
  logic [IDX_W-1:0] pix_cnt;
  logic [IDX_W-1:0] conv_idx;
  logic             outstanding;
  logic             rise_c;
  logic             fall_c;
  logic             adc_accept_c;
  logic             clr_overrun_c;

  // Reset asserts asynchronously, releases two clk_3M edges later.
  always_ff @(posedge clk_3M or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  assign rise_c        = sensor_clk & ~sclk_q;
  assign fall_c        = ~sensor_clk & sclk_q;
  assign adc_accept_c  = adc_valid & outstanding;
  assign clr_overrun_c = (state == ST_IDLE) && start;

  // Scan sequencer: frame start, per-pixel conversion strobes, drain and done.
  always_ff @(posedge clk_3M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sclk_q       <= 1'b0;
      si           <= 1'b0;
      si_rise_seen <= 1'b0;
      adc_conv     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      pix_cnt      <= '0;
      conv_idx     <= '0;
      outstanding  <= 1'b0;
    end else begin
      sclk_q     <= sensor_clk;
      adc_conv   <= 1'b0;
      frame_done <= 1'b0;
      if (adc_accept_c) begin
        outstanding <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_ARM;
          end
        end

        ST_ARM: begin
          si_rise_seen <= 1'b0;
          if (fall_c) begin
            si    <= 1'b1;
            state <= ST_SI;
          end
        end

        // SI is clocked in on the rise; pixel 0 converts on the following fall.
        ST_SI: begin
          if (rise_c) begin
            pix_cnt      <= '0;
            si_rise_seen <= 1'b1;
          end else if (fall_c && si_rise_seen) begin
            si           <= 1'b0;
            si_rise_seen <= 1'b0;
            adc_conv     <= 1'b1;
            conv_idx     <= '0;
            outstanding  <= 1'b1;
            state        <= ST_SHIFT;
          end
        end

        // The rise after the last pixel's conversion ends sensor readout.
        ST_SHIFT: begin
          if (rise_c) begin
            if (pix_cnt == LAST_IDX) begin
              state <= ST_DRAIN;
            end else begin
              pix_cnt <= pix_cnt + IDX_W'(1);
            end
          end else if (fall_c) begin
            adc_conv    <= 1'b1;
            conv_idx    <= pix_cnt;
            outstanding <= 1'b1;
          end
        end

        // Finish once the last conversion has returned and been consumed.
        ST_DRAIN: begin
          if (!outstanding && !pix_valid) begin
            frame_done <= 1'b1;
`ifdef SCAN_CONTINUOUS_EN
            state      <= ST_ARM;
`else
            busy       <= 1'b0;
            state      <= ST_IDLE;
`endif
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  pix_out_buf #(
    .DATA_W   (ADC_W),
    .IDX_W    (IDX_W),
    .LAST_IDX (NUM_PIXELS - 1)
  ) u_pix_out_buf (
    .clk         (clk_3M),
    .rst_n       (rst_n),
    .load        (adc_accept_c),
    .load_data   (adc_data),
    .load_idx    (conv_idx),
    .clr_overrun (clr_overrun_c),
    .ready       (pix_ready),
    .valid       (pix_valid),
    .data        (pix_data),
    .idx         (pix_idx),
    .last        (pix_last),
    .overrun     (overrun)
  );

endmodule

// File: tb/tb_sensor_scan_controller.sv
// Bench for sensor_scan_controller: sensor clock divider and ADC models plus
// a scoreboard of expected {data, idx} pushed at each convert strobe.
// Define SCAN_CONTINUOUS_EN for both bench and RTL to cover free-running mode.
module tb_sensor_scan_controller;

  localparam int NP = 128;

  typedef struct {
    logic [11:0] data;
    int          idx;
  } exp_t;

  logic        clk_3M = 1'b0;
  logic        reset;
  logic        sensor_clk = 1'b0;
  logic        start;
  logic        si;
  logic        adc_conv;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [11:0] pix_data;
  logic [6:0]  pix_idx;
  logic        pix_last;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  logic        spur_valid;
  logic [3:0]  pipe_v = '0;
  logic [11:0] pipe_d [4];
  int          conv_num = 0;
  int          div = 0;
  exp_t        sb [$];

  int checks = 0;
  int errors = 0;

  sensor_scan_controller #(.NUM_PIXELS(NP), .ADC_W(12)) dut (
    .clk_3M     (clk_3M),
    .reset      (reset),
    .sensor_clk (sensor_clk),
    .start      (start),
    .si         (si),
    .adc_conv   (adc_conv),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .pix_data   (pix_data),
    .pix_idx    (pix_idx),
    .pix_last   (pix_last),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk_3M = ~clk_3M;

  // Sensor clock: divide by 16, synchronous to clk_3M.
  always @(posedge clk_3M) begin
    if (div == 7) begin
      div        <= 0;
      sensor_clk <= ~sensor_clk;
    end else begin
      div <= div + 1;
    end
  end

  // ADC: result 4 cycles after each strobe; expected sample queued at strobe.
  always @(posedge clk_3M) begin : adc_model
    logic [11:0] d;
    d = 12'($urandom);
    pipe_v    <= {pipe_v[2:0], adc_conv};
    pipe_d[0] <= d;
    pipe_d[1] <= pipe_d[0];
    pipe_d[2] <= pipe_d[1];
    pipe_d[3] <= pipe_d[2];
    if (si) begin
      conv_num <= 0;
    end else if (adc_conv) begin
      conv_num <= conv_num + 1;
      sb.push_back('{d, conv_num});
    end
  end

  assign adc_valid = pipe_v[3] | spur_valid;
  assign adc_data  = spur_valid ? 12'hABC : pipe_d[3];

  // Start a frame and watch it to completion, scoring every output transfer.
  task automatic run_frame(input int start_again_at, input int frames,
                           output int n_xfer, output int n_done, output int n_rise,
                           output int n_si_rise, output int n_busy_low);
    bit   si_seen;
    bit   prev_sclk;
    int   post;
    exp_t e;
    n_xfer = 0; n_done = 0; n_rise = 0; n_si_rise = 0; n_busy_low = 0;
    si_seen = 0; post = -1;
    sb.delete();
    @(negedge clk_3M); start = 1'b1;
    @(negedge clk_3M); start = 1'b0;
    prev_sclk = sensor_clk;
    for (int cyc = 0; cyc < frames * 2400 + 200; cyc++) begin
      start = (cyc == start_again_at);
      if (si) si_seen = 1;
      if (sensor_clk && !prev_sclk && si_seen && n_done == 0) begin
        n_rise++;
        if (si) n_si_rise++;
      end
      prev_sclk = sensor_clk;
      if (pix_valid && pix_ready) begin
        n_xfer++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected got idx=%0d data=%h, scoreboard empty", pix_idx, pix_data);
        end else begin
          e = sb.pop_front();
          if (pix_data !== e.data || int'(pix_idx) !== e.idx || pix_last !== (e.idx == NP - 1)) begin
            errors++;
            $display("FAIL xfer got idx=%0d data=%h last=%0b exp idx=%0d data=%h last=%0b",
                     pix_idx, pix_data, pix_last, e.idx, e.data, (e.idx == NP - 1));
          end
        end
      end
      if (frame_done) begin
        n_done++;
        if (n_done == frames) post = 20;
      end
      if (!busy && n_done < frames) n_busy_low++;
      if (post == 0) break;
      if (post > 0) post--;
      @(negedge clk_3M);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pix_ready = 1'b1; spur_valid = 1'b0;
    repeat (10) @(negedge clk_3M);
    checks++;
    if ({si, adc_conv, pix_valid, pix_last, busy, frame_done, overrun} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got si/conv/pv/last/busy/done/ovr=%b exp 0000000",
               {si, adc_conv, pix_valid, pix_last, busy, frame_done, overrun});
    end
    checks++;
    if (pix_data !== 12'h000 || pix_idx !== 7'd0) begin
      errors++;
      $display("FAIL reset_pix got data=%h idx=%0d exp 000/0", pix_data, pix_idx);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk_3M);
    checks++;
    if (busy !== 1'b0 || si !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%0b si=%0b exp 0/0", busy, si);
    end
  endtask

`ifdef SCAN_CONTINUOUS_EN
  task automatic test_continuous();
    int nx, nd, nr, nsr, nbl;
    run_frame(-1, 3, nx, nd, nr, nsr, nbl);
    checks++;
    if (nd !== 3) begin errors++; $display("FAIL cont_done got %0d exp 3", nd); end
    checks++;
    if (nx !== 3 * NP) begin errors++; $display("FAIL cont_xfer got %0d exp %0d", nx, 3 * NP); end
    checks++;
    if (nbl !== 0) begin errors++; $display("FAIL cont_busy_low got %0d cycles exp 0", nbl); end
    checks++;
    if (nr !== NP + 1) begin errors++; $display("FAIL cont_rises got %0d exp %0d", nr, NP + 1); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_end got %0b exp 1", busy); end
  endtask
`else
  task automatic test_basic_frame();
    int nx, nd, nr, nsr, nbl;
    run_frame(-1, 1, nx, nd, nr, nsr, nbl);
    checks++;
    if (nx !== NP) begin errors++; $display("FAIL basic_xfer got %0d exp %0d", nx, NP); end
    checks++;
    if (nd !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", nd); end
    checks++;
    if (nr !== NP + 1) begin errors++; $display("FAIL basic_rises got %0d exp %0d", nr, NP + 1); end
    checks++;
    if (nsr !== 1) begin errors++; $display("FAIL basic_si_rises got %0d exp 1", nsr); end
    checks++;
    if (nbl !== 0) begin errors++; $display("FAIL basic_busy_low got %0d exp 0", nbl); end
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got overrun=%0b busy=%0b exp 0/0", overrun, busy);
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL basic_leftover got %0d exp 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int nv, nd, nx;
    bit ov_checked;
    sb.delete();
    pix_ready = 1'b0;
    nv = 0; nd = 0; ov_checked = 0;
    @(negedge clk_3M); start = 1'b1;
    @(negedge clk_3M); start = 1'b0;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      if (frame_done) nd++;
      if (nv == 2 && !ov_checked) begin
        ov_checked = 1;
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun_2nd got %0b exp 1", overrun); end
      end
      if (adc_valid) nv++;
      @(negedge clk_3M);
    end
    checks++;
    if (!ov_checked) begin errors++; $display("FAIL bp_adc_valid_count got %0d exp >=2", nv); end
    checks++;
    if (sb.size() == 0 || pix_valid !== 1'b1 || pix_idx !== 7'd0 || pix_data !== sb[0].data) begin
      errors++;
      $display("FAIL bp_held got valid=%0b idx=%0d data=%h exp 1/0/first sample", pix_valid, pix_idx, pix_data);
    end
    checks++;
    if (nd !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_stalled got done=%0d busy=%0b exp 0/1", nd, busy);
    end
    pix_ready = 1'b1;
    nx = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (pix_valid && pix_ready) nx++;
      if (frame_done) nd++;
      @(negedge clk_3M);
    end
    checks++;
    if (nx !== 1 || nd !== 1) begin
      errors++;
      $display("FAIL bp_release got xfer=%0d done=%0d exp 1/1", nx, nd);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int nd, npv, nx, nr, nsr, nbl;
    found = 0;
    @(negedge clk_3M); start = 1'b1;
    @(negedge clk_3M); start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (pix_valid && pix_idx == 7'd60) begin
        found = 1;
        break;
      end
      @(negedge clk_3M);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reach_60 got none exp idx 60 seen"); end
    reset = 1'b0;
    #1;
    checks++;
    if ({si, pix_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL mid_abort got si/pv/busy=%b exp 000", {si, pix_valid, busy});
    end
    repeat (3) @(negedge clk_3M);
    reset = 1'b1;
    nd = 0; npv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk_3M);
      if (frame_done) nd++;
      if (pix_valid) npv++;
    end
    checks++;
    if (nd !== 0 || npv !== 0) begin
      errors++;
      $display("FAIL mid_quiet got done=%0d pv=%0d exp 0/0", nd, npv);
    end
    run_frame(-1, 1, nx, nd, nr, nsr, nbl);
    checks++;
    if (nx !== NP || nd !== 1) begin
      errors++;
      $display("FAIL mid_restart got xfer=%0d done=%0d exp %0d/1", nx, nd, NP);
    end
  endtask

  task automatic test_start_ignored();
    int nx, nd, nr, nsr, nbl, npv;
    run_frame(600, 1, nx, nd, nr, nsr, nbl);
    checks++;
    if (nx !== NP || nd !== 1) begin
      errors++;
      $display("FAIL busy_start got xfer=%0d done=%0d exp %0d/1", nx, nd, NP);
    end
    repeat (100) @(negedge clk_3M);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got busy=%0b exp 0", busy); end
    spur_valid = 1'b1;
    @(negedge clk_3M);
    spur_valid = 1'b0;
    npv = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (pix_valid) npv++;
      @(negedge clk_3M);
    end
    checks++;
    if (npv !== 0) begin errors++; $display("FAIL spurious_valid got pv cycles=%0d exp 0", npv); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SCAN_CONTINUOUS_EN
    test_continuous();
`else
    test_basic_frame();
    test_backpressure();
    test_reset_mid_frame();
    test_start_ignored();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
